// File: rtl/prefix_addsub16_pipe_pkg.sv
// Shared constants, stage payload types and the prefix carry operator
// for the pipelined 16-bit add/subtract unit.
package prefix_addsub16_pipe_pkg;

    localparam int   ADD_W  = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Stage-1 payload: level-2 group (g,p), raw propagate bits and op (op doubles as cin).
    typedef struct packed {
        logic [ADD_W-1:0] g;
        logic [ADD_W-1:0] p;
        logic [ADD_W-1:0] pb;
        logic             op;
    } s1_t;

    typedef struct packed {
        logic [ADD_W-1:0] s;
        logic             c;
        logic             z;
        logic             v;
    } s2_t;

    // Prefix node: {gp, pp} = {g1 | p1&g0, p1&p0}.
    function automatic logic [1:0] carry_op(input logic g1, input logic p1,
                                            input logic g0, input logic p0);
        return {g1 | (p1 & g0), p1 & p0};
    endfunction

endpackage

// File: rtl/prefix_addsub16_pipe_stage.sv
// Valid/ready register slice: captures data_i whenever a beat is accepted
// and holds it until the downstream side takes it.
module prefix_addsub16_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign load       = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = load | (valid_q & ~out_ready_i);
        data_d  = load ? data_i : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data_o      = data_q;

endmodule

// File: rtl/prefix_addsub16_pipe.sv
// Two-stage 16-bit add/subtract on a Han-Carlson style prefix network:
// levels 1-2 before the stage-1 register, levels 3-5 and sum/flags after it.
module prefix_addsub16_pipe
    import prefix_addsub16_pipe_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cflag,
    output logic             zflag,
    output logic             vflag
);

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid, s2_ready;

    logic [ADD_W-1:0] be, pb, gb, g0;
    logic [ADD_W-1:0] gl1, pl1, gl2, pl2;
    logic [ADD_W-1:0] gl3, pl3, gl4, pl4, gl5;
    logic [ADD_W-1:0] sum;

    // Stage 0 -> 1: operand inversion, cin folded into bit 0, odd-position levels 1-2.
    always_comb begin
        be    = x2 ^ {ADD_W{op}};
        pb    = x1 ^ be;
        gb    = x1 & be;
        g0    = gb;
        g0[0] = gb[0] | (pb[0] & op);
        gl1   = g0;
        pl1   = pb;
        for (int i = 1; i < ADD_W; i += 2)
            {gl1[i], pl1[i]} = carry_op(g0[i], pb[i], g0[i-1], pb[i-1]);
        gl2 = gl1;
        pl2 = pl1;
        for (int i = 3; i < ADD_W; i += 2)
            {gl2[i], pl2[i]} = carry_op(gl1[i], pl1[i], gl1[i-2], pl1[i-2]);
        s1_d.g  = gl2;
        s1_d.p  = pl2;
        s1_d.pb = pb;
        s1_d.op = op;
    end

    prefix_addsub16_pipe_stage #(.W($bits(s1_t))) u_stage1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .data_i      (s1_d),
        .data_o      (s1_q)
    );

    // Stage 1 -> 2: odd levels 3-4, even fix-up level 5, sum XORs and flags.
    always_comb begin
        gl3 = s1_q.g;
        pl3 = s1_q.p;
        for (int i = 5; i < ADD_W; i += 2)
            {gl3[i], pl3[i]} = carry_op(s1_q.g[i], s1_q.p[i], s1_q.g[i-4], s1_q.p[i-4]);
        gl4 = gl3;
        pl4 = pl3;
        for (int i = 9; i < ADD_W; i += 2)
            {gl4[i], pl4[i]} = carry_op(gl3[i], pl3[i], gl3[i-8], pl3[i-8]);
        gl5 = gl4;
        for (int i = 2; i < ADD_W; i += 2)
            gl5[i] = carry_op(gl4[i], pl4[i], gl4[i-1], pl4[i-1])[1];
        sum    = '0;
        sum[0] = s1_q.pb[0] ^ s1_q.op;
        for (int i = 1; i < ADD_W; i++)
            sum[i] = s1_q.pb[i] ^ gl5[i-1];
        s2_d.s = sum;
        s2_d.c = gl4[ADD_W-1] ^ s1_q.op;
        s2_d.z = ~|sum;
        s2_d.v = gl5[ADD_W-2] ^ gl4[ADD_W-1];
    end

    prefix_addsub16_pipe_stage #(.W($bits(s2_t))) u_stage2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_i      (s2_d),
        .data_o      (s2_q)
    );

    assign s     = s2_q.s;
    assign cflag = s2_q.c;
    assign zflag = s2_q.z;
    assign vflag = s2_q.v;

endmodule
